// File: rtl/sdram_arb_pkg.sv
// Shared types and the round-robin search used by the SDRAM command arbiter.
package sdram_arb_pkg;

   localparam int unsigned NUM_REQ_MAX = 16;
   localparam int unsigned REQ_IDX_W   = $clog2(NUM_REQ_MAX);
   localparam int unsigned IDX_EXT_W   = REQ_IDX_W + 1;

   typedef logic [REQ_IDX_W-1:0] req_idx_t;

   typedef struct packed {
      logic     found;
      req_idx_t idx;
   } rr_pick_t;

   // First set bit of elig at or after ptr, wrapping modulo num (ptr < num assumed).
   function automatic rr_pick_t rr_search(input logic [NUM_REQ_MAX-1:0] elig,
                                          input req_idx_t ptr,
                                          input int unsigned num);
      rr_pick_t             res;
      logic [IDX_EXT_W-1:0] cand;
      res = '0;
      for (int unsigned i = 0; i < NUM_REQ_MAX; i++) begin
         cand = IDX_EXT_W'(ptr) + IDX_EXT_W'(i);
         if (cand >= IDX_EXT_W'(num)) cand = cand - IDX_EXT_W'(num);
         if (!res.found && (i < num) && elig[cand[REQ_IDX_W-1:0]]) begin
            res.found = 1'b1;
            res.idx   = cand[REQ_IDX_W-1:0];
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/sdram_ctrl_if.sv
// Command/return port of the SDRAM controller; the arbiter drives it through modport man.
interface sdram_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 24
);
   localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

   logic                  rdy;
   logic                  rd;
   logic [STRB_WIDTH-1:0] wr;
   logic [ADDR_WIDTH-1:0] addr;
   logic [DATA_WIDTH-1:0] write_data;
   logic [DATA_WIDTH-1:0] read_data;
   logic                  valid;

   modport man (input rdy, read_data, valid, output rd, wr, addr, write_data);
   modport sub (output rdy, read_data, valid, input rd, wr, addr, write_data);
endinterface

// File: rtl/sdram_arb_tag_fifo.sv
// In-order FIFO of requester indices for outstanding reads; same-cycle push and pop allowed.
module sdram_arb_tag_fifo
   import sdram_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  req_idx_t                   din,
   output req_idx_t                   dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   req_idx_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == CNT_W'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/sdram_arb.sv
// Shares one SDRAM controller command port among NUM_REQ requesters and steers read data back.
// Define SDRAM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module sdram_arb
   import sdram_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 24,
   parameter int unsigned STRB_W    = DATA_W / 8,
   parameter int unsigned TAG_DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_REQ-1:0]         req_rd,
   input  logic [NUM_REQ*STRB_W-1:0]  req_wr,
   input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]         req_gnt,
   output logic [NUM_REQ-1:0]         req_rvalid,
   output logic [DATA_W-1:0]          req_rdata,
   output logic                       err_unexp,
   sdram_ctrl_if.man                  sdram_ctrl
);
   localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

   if ($bits(sdram_ctrl.write_data) != DATA_W || $bits(sdram_ctrl.read_data) != DATA_W ||
       $bits(sdram_ctrl.addr) != ADDR_W || $bits(sdram_ctrl.wr) != STRB_W) begin : g_width_chk
      $fatal(1, "sdram_arb: width mismatch with sdram_ctrl");
   end
   if (TAG_DEPTH < 2 || (TAG_DEPTH & (TAG_DEPTH - 1)) != 0) begin : g_depth_chk
      $fatal(1, "sdram_arb: TAG_DEPTH must be a power of two");
   end
   if (NUM_REQ < 2 || NUM_REQ > NUM_REQ_MAX) begin : g_nreq_chk
      $fatal(1, "sdram_arb: NUM_REQ must be in 2..16");
   end

   logic [NUM_REQ-1:0] wr_act;
   logic [NUM_REQ-1:0] elig;
   rr_pick_t           pick;
   req_idx_t           base_idx;
   logic               gnt_fire;
   logic               cmd_rd;
   logic [STRB_W-1:0]  cmd_wr;
   logic [ADDR_W-1:0]  cmd_addr;
   logic [DATA_W-1:0]  cmd_wdata;
   logic               tag_push;
   logic               tag_pop;
   req_idx_t           tag_head;
   logic [CNT_W-1:0]   tag_count;
   logic               tag_full;
   logic               tag_empty;

   // Reads need a free tag slot (registered count); writes are always eligible.
   always_comb begin
      wr_act = '0;
      elig   = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         wr_act[i] = |req_wr[i*STRB_W +: STRB_W];
         elig[i]   = wr_act[i] | (req_rd[i] & ~tag_full);
      end
   end

`ifdef SDRAM_ARB_FIXED_PRIO_EN
   assign base_idx = '0;
`else
   req_idx_t rr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (gnt_fire) begin
         rr_ptr <= (pick.idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0 : pick.idx + REQ_IDX_W'(1);
      end
   end

   assign base_idx = rr_ptr;
`endif

   assign pick     = rr_search(NUM_REQ_MAX'(elig), base_idx, NUM_REQ);
   assign gnt_fire = pick.found & sdram_ctrl.rdy & ~rst;
   assign req_gnt  = gnt_fire ? (NUM_REQ'(1) << pick.idx) : '0;

   // One-hot grant lets the command mux be a plain OR of the selected fields.
   always_comb begin
      cmd_rd    = 1'b0;
      cmd_wr    = '0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (req_gnt[i]) begin
            cmd_rd    = cmd_rd    | (req_rd[i] & ~wr_act[i]);
            cmd_wr    = cmd_wr    | req_wr[i*STRB_W +: STRB_W];
            cmd_addr  = cmd_addr  | req_addr[i*ADDR_W +: ADDR_W];
            cmd_wdata = cmd_wdata | req_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   assign sdram_ctrl.rd         = cmd_rd;
   assign sdram_ctrl.wr         = cmd_wr;
   assign sdram_ctrl.addr       = cmd_addr;
   assign sdram_ctrl.write_data = cmd_wdata;

   assign tag_push = gnt_fire & cmd_rd;
   assign tag_pop  = sdram_ctrl.valid & (tag_count != '0);

   sdram_arb_tag_fifo #(.DEPTH(TAG_DEPTH)) u_tag_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tag_push),
      .pop   (tag_pop),
      .din   (pick.idx),
      .dout  (tag_head),
      .count (tag_count),
      .full  (tag_full),
      .empty (tag_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         req_rvalid <= '0;
         req_rdata  <= '0;
         err_unexp  <= 1'b0;
      end else begin
         req_rvalid <= tag_pop ? (NUM_REQ'(1) << tag_head) : '0;
         if (tag_pop) req_rdata <= sdram_ctrl.read_data;
         if (sdram_ctrl.valid && tag_empty) err_unexp <= 1'b1;
      end
   end

endmodule

// File: tb/tb_sdram_arb.sv
// Bench for sdram_arb: directed scenarios plus random traffic checked against a queue-based model.
module tb_sdram_arb;
   localparam int N  = 4;
   localparam int DW = 32;
   localparam int AW = 24;
   localparam int SW = 4;
   localparam int TD = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic [N-1:0]    req_rd;
   logic [N*SW-1:0] req_wr;
   logic [N*AW-1:0] req_addr;
   logic [N*DW-1:0] req_wdata;
   logic [N-1:0]    req_gnt;
   logic [N-1:0]    req_rvalid;
   logic [DW-1:0]   req_rdata;
   logic            err_unexp;

   sdram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ctrl_if ();

   sdram_arb #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW), .STRB_W(SW), .TAG_DEPTH(TD)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_rd     (req_rd),
      .req_wr     (req_wr),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_gnt    (req_gnt),
      .req_rvalid (req_rvalid),
      .req_rdata  (req_rdata),
      .err_unexp  (err_unexp),
      .sdram_ctrl (ctrl_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int ctrl_pending = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model state, as seen after the most recent rising edge.
   int           m_ptr = 0;
   int           m_tags[$];
   logic [N-1:0] m_rvalid = '0;
   logic [DW-1:0] m_rdata = '0;
   logic         m_err = 1'b0;
   bit           m_init = 1'b0;

   always @(negedge clk) begin : model_chk
      int            win;
      int            idx;
      int            base;
      int            head;
      logic [N-1:0]  e_gnt;
      logic          e_rd;
      logic [SW-1:0] e_wr;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_wd;
      if (m_init) begin
         chk("rvalid", 64'(req_rvalid), 64'(m_rvalid));
         chk("rdata", 64'(req_rdata), 64'(m_rdata));
         chk("err_unexp", 64'(err_unexp), 64'(m_err));
      end
`ifdef SDRAM_ARB_FIXED_PRIO_EN
      base = 0;
`else
      base = m_ptr;
`endif
      win = -1;
      if (!rst && ctrl_if.rdy) begin
         for (int j = 0; j < N; j++) begin
            idx = (base + j) % N;
            if (win < 0 && ((req_wr[idx*SW +: SW] != '0) || (req_rd[idx] && m_tags.size() < TD)))
               win = idx;
         end
      end
      e_gnt = '0; e_rd = 1'b0; e_wr = '0; e_addr = '0; e_wd = '0;
      if (win >= 0) begin
         e_gnt  = N'(1) << win;
         e_wr   = req_wr[win*SW +: SW];
         e_rd   = (e_wr == '0);
         e_addr = req_addr[win*AW +: AW];
         e_wd   = req_wdata[win*DW +: DW];
      end
      chk("gnt", 64'(req_gnt), 64'(e_gnt));
      chk("ctrl_rd", 64'(ctrl_if.rd), 64'(e_rd));
      chk("ctrl_wr", 64'(ctrl_if.wr), 64'(e_wr));
      chk("ctrl_addr", 64'(ctrl_if.addr), 64'(e_addr));
      chk("ctrl_wdata", 64'(ctrl_if.write_data), 64'(e_wd));
      if (rst) begin
         m_ptr = 0; m_tags.delete(); m_rvalid = '0; m_rdata = '0; m_err = 1'b0; m_init = 1'b1;
      end else begin
         m_rvalid = '0;
         if (ctrl_if.valid) begin
            if (m_tags.size() > 0) begin
               head     = m_tags.pop_front();
               m_rvalid = N'(1) << head;
               m_rdata  = ctrl_if.read_data;
            end else begin
               m_err = 1'b1;
            end
         end
         if (win >= 0) begin
            if (e_rd) begin
               m_tags.push_back(win);
               ctrl_pending++;
            end
            m_ptr = (win + 1) % N;
         end
      end
   end

   logic [N-1:0] g_last = '0;

   task automatic to_neg();
      @(negedge clk);
      g_last = req_gnt;
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
      ctrl_if.valid = 1'b0;
   endtask

   task automatic step();
      to_neg();
      to_pos();
   endtask

   task automatic step_gnt(input logic [N-1:0] e, input string nm);
      to_neg();
      chk(nm, 64'(req_gnt), 64'(e));
      to_pos();
   endtask

   task automatic ret(input logic [DW-1:0] d);
      ctrl_if.valid     = 1'b1;
      ctrl_if.read_data = d;
      ctrl_pending--;
   endtask

   task automatic set_req(input int i, input logic rd, input logic [SW-1:0] w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_rd[i]            = rd;
      req_wr[i*SW +: SW]   = w;
      req_addr[i*AW +: AW] = a;
      req_wdata[i*DW +: DW] = d;
   endtask

   bit            pend [N];
   int            kind;

   initial begin
      rst = 1'b1; req_rd = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
      ctrl_if.rdy = 1'b0; ctrl_if.valid = 1'b0; ctrl_if.read_data = '0;
      #1;
      repeat (3) step();
      rst = 1'b0;
      to_neg();
      chk("rst_rvalid", 64'(req_rvalid), 64'h0);
      chk("rst_rdata", 64'(req_rdata), 64'h0);
      chk("rst_err", 64'(err_unexp), 64'h0);
      to_pos();

      // Round-robin fairness with all four writing continuously
      ctrl_if.rdy = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'hF, AW'(i * 16), DW'($urandom));
      step_gnt(4'b0001, "rr_0");
      step_gnt(4'b0010, "rr_1");
      step_gnt(4'b0100, "rr_2");
      step_gnt(4'b1000, "rr_3");
      step_gnt(4'b0001, "rr_4");
      step_gnt(4'b0010, "rr_5");
      req_wr = '0;

      // Read steering
      set_req(2, 1'b1, 4'h0, 24'h000100, '0);
      set_req(0, 1'b1, 4'h0, 24'h000200, '0);
      to_neg();
      chk("steer_gnt_a", 64'(req_gnt), 64'h4);
      chk("steer_addr_a", 64'(ctrl_if.addr), 64'h000100);
      to_pos();
      req_rd[2] = 1'b0;
      to_neg();
      chk("steer_gnt_b", 64'(req_gnt), 64'h1);
      chk("steer_addr_b", 64'(ctrl_if.addr), 64'h000200);
      to_pos();
      req_rd[0] = 1'b0;
      ret(32'hAAAA0001);
      step();
      ret(32'hBBBB0002);
      to_neg();
      chk("steer_rvalid_a", 64'(req_rvalid), 64'h4);
      chk("steer_rdata_a", 64'(req_rdata), 64'hAAAA0001);
      to_pos();
      to_neg();
      chk("steer_rvalid_b", 64'(req_rvalid), 64'h1);
      chk("steer_rdata_b", 64'(req_rdata), 64'hBBBB0002);
      to_pos();

      // Tag FIFO full: writes still pass, the read waits for a pop
      req_rd[0] = 1'b1;
      repeat (TD) step_gnt(4'b0001, "fill_gnt");
      req_rd[0] = 1'b0;
      set_req(1, 1'b1, 4'h0, 24'h000300, '0);
      set_req(3, 1'b0, 4'hF, 24'h000400, 32'h0BADF00D);
      step_gnt(4'b1000, "full_wr_gnt");
      req_wr = '0;
      step_gnt(4'b0000, "full_hold");
      ret(DW'($urandom));
      step_gnt(4'b0000, "full_pop_cycle");
      step_gnt(4'b0010, "full_after_pop");
      req_rd = '0;
      repeat (TD) begin
         ret(DW'($urandom));
         step();
      end
      step();

      // rdy low holds everything, including the pointer
      for (int i = 0; i < N; i++) set_req(i, 1'b0, 4'hF, AW'($urandom), DW'($urandom));
      ctrl_if.rdy = 1'b0;
      repeat (5) begin
         to_neg();
         chk("rdy_lo_gnt", 64'(req_gnt), 64'h0);
         chk("rdy_lo_rd", 64'(ctrl_if.rd), 64'h0);
         chk("rdy_lo_wr", 64'(ctrl_if.wr), 64'h0);
         to_pos();
      end
      ctrl_if.rdy = 1'b1;
      step_gnt(4'b0100, "rdy_resume");
      req_wr = '0;

      // Read and write together: the write goes out
      set_req(0, 1'b1, 4'hF, 24'h000500, 32'h11223344);
      to_neg();
      chk("rdwr_gnt", 64'(req_gnt), 64'h1);
      chk("rdwr_rd", 64'(ctrl_if.rd), 64'h0);
      chk("rdwr_wr", 64'(ctrl_if.wr), 64'hF);
      to_pos();
      req_rd = '0; req_wr = '0;
      step();

      // Reset with reads in flight, then a stale return
      req_rd[0] = 1'b1;
      repeat (3) step_gnt(4'b0001, "pre_rst_gnt");
      req_rd = '0;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      ctrl_pending = 0;
      ctrl_if.valid = 1'b1;
      ctrl_if.read_data = 32'hDEADBEEF;
      step();
      to_neg();
      chk("stale_err", 64'(err_unexp), 64'h1);
      chk("stale_rvalid", 64'(req_rvalid), 64'h0);
      to_pos();
      set_req(1, 1'b1, 4'h0, 24'h000600, '0);
      step_gnt(4'b0010, "post_rst_gnt");
      req_rd = '0;
      ret(32'h12345678);
      step();
      to_neg();
      chk("post_rst_rvalid", 64'(req_rvalid), 64'h2);
      chk("post_rst_rdata", 64'(req_rdata), 64'h12345678);
      to_pos();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      to_neg();
      chk("err_cleared", 64'(err_unexp), 64'h0);
      to_pos();

      // Random traffic
      for (int i = 0; i < N; i++) pend[i] = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (g_last[i]) pend[i] = 1'b0;
            if (!pend[i] && $urandom_range(0, 3) == 0) begin
               pend[i] = 1'b1;
               kind = int'($urandom_range(0, 2));
               set_req(i, kind != 1, (kind == 0) ? 4'h0 : SW'($urandom_range(1, 15)),
                       AW'($urandom), DW'($urandom));
            end
            if (!pend[i]) set_req(i, 1'b0, 4'h0, '0, '0);
         end
         ctrl_if.rdy = ($urandom_range(0, 4) != 0);
         if (ctrl_pending > 0 && $urandom_range(0, 2) == 0) ret(DW'($urandom));
         step();
      end

      // Drain outstanding reads
      req_rd = '0; req_wr = '0;
      ctrl_if.rdy = 1'b0;
      for (int b = 0; b < 200 && ctrl_pending > 0; b++) begin
         ret(DW'($urandom));
         step();
      end
      chk("drain_done", 64'(ctrl_pending), 64'h0);
      step();
      step();
      chk("tags_empty", 64'(m_tags.size()), 64'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sdram_arb.md
# sdram_arb

Round-robin arbiter that shares one SDRAM controller command port among NUM_REQ independent requesters. It sits between the requester-side masters (AXI-Lite bridges, DMA engines, video fetch) and the `sdram_ctrl_if.man` port that drives the controller. Every read command is tagged with its requester index in an in-order tag FIFO, so returning read data is steered back to the requester that issued it.

## Interface
Parameters:
- NUM_REQ, 4: number of requester ports (2..16).
- DATA_W, 32: data width; must equal `sdram_ctrl.DATA_WIDTH`.
- ADDR_W, 24: address width; must equal `sdram_ctrl.ADDR_WIDTH`.
- STRB_W, DATA_W/8: byte-strobe width.
- TAG_DEPTH, 8: maximum outstanding reads; power of two.

Ports. Reset is `rst`, synchronous, active-high; the clock is `clk`.
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_rd  in  NUM_REQ  per-requester read request
- req_wr  in  NUM_REQ*STRB_W  per-requester write strobes; any bit set means a write request
- req_addr  in  NUM_REQ*ADDR_W  per-requester address
- req_wdata  in  NUM_REQ*DATA_W  per-requester write data
- req_gnt  out  NUM_REQ  one-hot command accept (combinational)
- req_rvalid  out  NUM_REQ  one-hot read-data valid (registered)
- req_rdata  out  DATA_W  shared read data (registered)
- err_unexp  out  1  sticky: controller returned data with no tag outstanding
- sdram_ctrl  if  `sdram_ctrl_if.man`  uses rdy, rd, wr, addr, write_data, read_data, valid

## Operation
- Requester i is active when `req_rd[i]` is set or `req_wr[i]` is nonzero.
  - If both are set, the write is issued and the read is ignored for that cycle.
  - A read-only request is eligible only when the tag FIFO is not full.
  - Writes are always eligible.
- Grant logic:
  - Grant fires only when `sdram_ctrl.rdy=1` and at least one eligible requester exists.
  - Winner: the first eligible index at or after `rr_ptr`, wrapping modulo NUM_REQ.
  - Exactly one `req_gnt` bit is high.
  - The winner's fields are muxed onto `sdram_ctrl`: `wr` gets the strobes, or `rd=1` with `wr=0`, plus `addr` and `write_data`.
  - With no grant, all `sdram_ctrl` outputs are 0.
- After a grant to index k, `rr_ptr <= (k+1) mod NUM_REQ`. Without a grant, `rr_ptr` holds.
- Read issue: a granted read pushes k into the tag FIFO.
- Read return: on `sdram_ctrl.valid`, the FIFO head is popped. The next cycle drives `req_rvalid[head]=1` and `req_rdata=read_data`.
- Unexpected return: `sdram_ctrl.valid` with the FIFO empty sets `err_unexp`. No `req_rvalid` is asserted for it.
- Push and pop in the same cycle are both performed and the count is unchanged.
  - Fullness for eligibility uses the registered count, so no push happens while the count equals TAG_DEPTH, even if a pop occurs that cycle.
- Requesters hold their request stable until `req_gnt` is seen. There are no wait states after a grant.
- Writes produce no return.

## Timing
- Command path is combinational: `req_gnt` and the `sdram_ctrl` command are asserted in the same cycle as `rdy` and the request.
- Read data reaches the requester one cycle after `sdram_ctrl.valid`.
  - Total read latency is controller latency plus 1.
  - `req_rvalid` is a single-cycle pulse. There is no backpressure on returns.
- Reset values:
  - `rr_ptr=0`; tag FIFO empty.
  - `req_rvalid=0`, `req_rdata=0`, `err_unexp=0`.
  - `req_gnt` and the `sdram_ctrl` outputs are 0 while `rst` is high; grants are suppressed during reset.
- Reset mid-operation discards all tags. Returns for pre-reset reads arrive with an empty FIFO and set `err_unexp`. This is intended: the system must quiesce the controller before a soft reset.
- Elaboration calls `$fatal` on a width mismatch with `sdram_ctrl`, on TAG_DEPTH not a power of two, or on NUM_REQ outside 2..16.

## Configuration
- `SDRAM_ARB_FIXED_PRIO_EN` defined:
  - Fixed priority; the lowest eligible index always wins.
  - `rr_ptr` is not implemented.
- Not defined: round-robin as described under Operation.
- Tag FIFO and return behaviour are identical in both modes.

## Structure
- Package `sdram_arb_pkg`:
  - `req_idx_t` (logic [$clog2(NUM_REQ_MAX)-1:0], with NUM_REQ_MAX=16).
  - A helper function implementing the round-robin one-hot search.
- Sub-module `sdram_arb_tag_fifo`: synchronous FIFO of `req_idx_t`, depth TAG_DEPTH.
  - Ports: push, pop, din, dout (head), count, full, empty.
  - Registered count; same-cycle push and pop supported.

## Test plan
- Round-robin fairness: NUM_REQ=4, all four request writes continuously with `rdy=1` -> grants are 0,1,2,3,0,1 on consecutive cycles, one-hot each cycle.
- Read steering: req 2 reads addr 0x000100 and req 0 reads 0x000200, controller returns 0xAAAA0001 then 0xBBBB0002 -> `req_rvalid[2]` carries 0xAAAA0001, then `req_rvalid[0]` carries 0xBBBB0002, each one cycle after its `valid`.
- Tag full: 8 reads outstanding, req 1 reads and req 3 writes -> req 3 is granted; req 1 is granted only in the cycle after the first return is popped.
- `rdy` low: requests pending while `rdy=0` for 5 cycles -> no `req_gnt`, `sdram_ctrl.rd=0`, `wr=0`, `rr_ptr` unchanged.
- Simultaneous rd and wr: req 0 has `req_rd=1` and `req_wr=4'hF` -> write issued, no tag pushed.
- Reset mid-flight: assert `rst` with 3 reads outstanding, then deliver 1 `valid` -> `err_unexp=1` and no `req_rvalid`; a subsequent read round-trips normally.
